uart_boot_loader: RTL and testbench
===================================

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width.
REQ-002 The module SHALL have parameter END_WORD, default 32'hFFFFFFFF, meaning the end-of-program marker word.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port rx_valid, input, 1 bit: one-cycle pulse per UART byte received.
REQ-006 The module SHALL have port rx_data, input, 8 bits: received byte, valid when rx_valid=1.
REQ-007 The module SHALL have port rx_break, input, 1 bit: UART BREAK detected, one-cycle pulse.
REQ-008 The module SHALL have port imem_we, output, 1 bit: instruction-memory write strobe, one cycle per word.
REQ-009 The module SHALL have port imem_addr, output, ADDR_W bits: word address for the write.
REQ-010 The module SHALL have port imem_wdata, output, 32 bits: assembled instruction word.
REQ-011 The module SHALL have port core_rst, output, 1 bit: active-high hold-reset for the CPU core.
REQ-012 The module SHALL have port load_done, output, 1 bit: high once the end marker is accepted.
REQ-013 The module SHALL have port load_err, output, 1 bit: high once address overflow occurs.

Function
REQ-014 The module SHALL implement states LOAD, DONE and ERROR; LOAD SHALL be entered on reset.
REQ-015 In LOAD, each rx_valid SHALL store rx_data into a 32-bit shift/assembly register at byte lane byte_cnt (little-endian: first byte -> [7:0], fourth -> [31:24]), and byte_cnt (2 bits) SHALL increment, wrapping 3->0.
REQ-016 On the rx_valid that completes a word (byte_cnt=3), if the word != END_WORD, the next cycle SHALL have imem_we=1, imem_wdata=word and imem_addr=current write address; the write address SHALL increment by 1 after the strobe.
REQ-017 imem_we SHALL be high for exactly one cycle per written word; imem_addr and imem_wdata SHALL be registered and stable during that cycle.
REQ-018 An rx_valid arriving in the same cycle as imem_we=1 SHALL be accepted as byte 0 of the next word.
REQ-019 If the completed word == END_WORD, no write SHALL occur, and the next cycle SHALL enter DONE with load_done=1 and core_rst=0.
REQ-020 If a non-END_WORD word completes when the previous write used address 2^ADDR_W-1, it SHALL NOT be written; the next cycle SHALL enter ERROR with load_err=1.
REQ-021 rx_break in LOAD SHALL discard any partial word (byte_cnt<-0) without a write; if rx_valid and rx_break coincide, rx_break SHALL win and the byte SHALL be discarded.
REQ-022 In DONE and ERROR, rx_valid and rx_break SHALL be ignored; both states SHALL be left only via rst.
REQ-023 core_rst SHALL be 1 in LOAD and ERROR and 0 only in DONE.

Reset
REQ-024 While rst=1 (asynchronous): state=LOAD, byte_cnt=0, write address=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, load_err=0.
REQ-025 rst asserted mid-word or mid-write SHALL abort immediately with no further imem_we; loading SHALL restart at address 0 after release.

Verification
REQ-026 Bytes 13,01,01,FD -> one-cycle imem_we, addr=0, wdata=32'hFD010113; then bytes 23,26,81,02 -> addr=1, wdata=32'h02812623.
REQ-027 Three words, then FF,FF,FF,FF, then FF,FF,FF,FF -> three writes (addr 0..2), no fourth write, load_done=1 and core_rst=0 one cycle after the 4th FF, second marker ignored.
REQ-028 Bytes 6F,F0 then rx_break, then 93,07,10,00 -> single write wdata=32'h00100793 at addr=0.
REQ-029 ADDR_W=2: five non-marker words -> writes at addr 0..3, fifth not written, load_err=1, core_rst stays 1.
REQ-030 rst pulsed after 2 bytes of word 1 (word 0 written) -> outputs return to reset values; next 4 bytes are written at addr=0.
REQ-031 rx_valid coincident with imem_we strobe (back-to-back bytes) -> byte lands in lane [7:0] of the next word with no byte lost.

Source files
------------

// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles little-endian 32-bit words from received bytes
// and writes them to consecutive instruction-memory addresses. It holds the CPU
// core in reset until the end-of-program marker word arrives. An address
// overflow latches an error state that only rst can clear.
module uart_boot_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DONE  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          byte_cnt;
    logic [31:0]         asm_word;
    logic [31:0]         word_nxt;
    logic [ADDR_W-1:0]   waddr;
    logic                addr_full;   // last write used the top address

    logic take_byte;
    logic word_done;
    logic is_end;

    // A break always wins over a coincident byte.
    assign take_byte = (state == S_LOAD) && rx_valid && !rx_break;
    assign word_done = take_byte && (byte_cnt == 2'd3);
    assign is_end    = (word_nxt == END_WORD);

    // Assembly register with the incoming byte merged into its lane.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_nxt = asm_word;
        case (byte_cnt)
            2'd0: word_nxt[7:0]   = rx_data;
            2'd1: word_nxt[15:8]  = rx_data;
            2'd2: word_nxt[23:16] = rx_data;
            2'd3: word_nxt[31:24] = rx_data;
            default: word_nxt = asm_word;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) state <= S_LOAD;
        else     state <= state_nxt;
    end

    // Next-state logic: DONE and ERROR are terminal until reset.
    always_comb begin
        state_nxt = state;
        if (word_done) begin
            if (is_end)         state_nxt = S_DONE;
            else if (addr_full) state_nxt = S_ERROR;
        end
    end

    // State-decoded status outputs.
    always_comb begin
        core_rst  = (state != S_DONE);
        load_done = (state == S_DONE);
        load_err  = (state == S_ERROR);
    end

    // Byte assembly, write address and registered memory write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            asm_word   <= 32'd0;
            waddr      <= '0;
            addr_full  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (state == S_LOAD) begin
                if (rx_break) begin
                    byte_cnt <= 2'd0;
                end else if (rx_valid) begin
                    asm_word <= word_nxt;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3 && !is_end && !addr_full) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= waddr;
                        imem_wdata <= word_nxt;
                        waddr      <= waddr + ADDR_W'(1);
                        addr_full  <= (waddr == {ADDR_W{1'b1}});
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: drives one byte stream into two instances
// (default ADDR_W=8 and ADDR_W=2) and compares both against a byte-queue
// model every cycle, plus literal expectations at key points.
module tb_uart_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_break;

    logic        imem_we0, imem_we1;
    logic [7:0]  imem_addr0;
    logic [1:0]  imem_addr1;
    logic [31:0] imem_wdata0, imem_wdata1;
    logic        core_rst0, core_rst1;
    logic        load_done0, load_done1;
    logic        load_err0, load_err1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_boot_loader u_dut0 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .imem_we(imem_we0), .imem_addr(imem_addr0),
        .imem_wdata(imem_wdata0), .core_rst(core_rst0),
        .load_done(load_done0), .load_err(load_err0)
    );

    uart_boot_loader #(.ADDR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .imem_we(imem_we1), .imem_addr(imem_addr1),
        .imem_wdata(imem_wdata1), .core_rst(core_rst1),
        .load_done(load_done1), .load_err(load_err1)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    // ---------------- behavioural model (one per instance) ----------------
    int          lim[2] = '{256, 4};
    bit          m_done[2];
    bit          m_err[2];
    int          m_nw[2];
    int          m_npend[2];
    logic [7:0]  m_pend[2][4];
    bit          e_we[2];
    logic [31:0] e_addr[2];
    logic [31:0] e_wdata[2];

    task automatic model_step();
        logic [31:0] w;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_done[m] = 0; m_err[m] = 0; m_nw[m] = 0; m_npend[m] = 0;
                e_we[m] = 0; e_addr[m] = 0; e_wdata[m] = 0;
            end else begin
                e_we[m] = 0;
                if (!m_done[m] && !m_err[m]) begin
                    if (rx_break) begin
                        m_npend[m] = 0;
                    end else if (rx_valid) begin
                        m_pend[m][m_npend[m]] = rx_data;
                        m_npend[m]++;
                        if (m_npend[m] == 4) begin
                            w = 32'(m_pend[m][0]) + 32'(m_pend[m][1]) * 256
                              + 32'(m_pend[m][2]) * 65536
                              + 32'(m_pend[m][3]) * 16777216;
                            m_npend[m] = 0;
                            if (w == 32'hFFFFFFFF)  m_done[m] = 1;
                            else if (m_nw[m] == lim[m]) m_err[m] = 1;
                            else begin
                                e_we[m] = 1; e_addr[m] = m_nw[m]; e_wdata[m] = w;
                                m_nw[m]++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        check("we0", {31'b0, imem_we0}, {31'b0, e_we[0]});
        check("we1", {31'b0, imem_we1}, {31'b0, e_we[1]});
        check("core_rst0", {31'b0, core_rst0}, {31'b0, !m_done[0]});
        check("core_rst1", {31'b0, core_rst1}, {31'b0, !m_done[1]});
        check("load_done0", {31'b0, load_done0}, {31'b0, m_done[0]});
        check("load_done1", {31'b0, load_done1}, {31'b0, m_done[1]});
        check("load_err0", {31'b0, load_err0}, {31'b0, m_err[0]});
        check("load_err1", {31'b0, load_err1}, {31'b0, m_err[1]});
        if (e_we[0] || rst) begin
            check("addr0", {24'b0, imem_addr0}, e_addr[0]);
            check("wdata0", imem_wdata0, e_wdata[0]);
        end
        if (e_we[1] || rst) begin
            check("addr1", {30'b0, imem_addr1}, e_addr[1]);
            check("wdata1", imem_wdata1, e_wdata[1]);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] bq[$];

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) bq.push_back(w[8*i +: 8]);
    endtask

    // Sends the queued bytes, one idle cycle between bytes unless b2b.
    // Returns at the negedge after the last byte's sampling edge.
    task automatic send_stream(input bit b2b);
        while (bq.size() > 0) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = bq.pop_front();
            if (!b2b) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        if (b2b) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"}, {31'b0, imem_we0}, 32'd0);
        check({tag, "_addr"}, {24'b0, imem_addr0}, 32'd0);
        check({tag, "_wdata"}, imem_wdata0, 32'd0);
        check({tag, "_core_rst"}, {31'b0, core_rst0}, 32'd1);
        check({tag, "_done"}, {31'b0, load_done0}, 32'd0);
        check({tag, "_err"}, {31'b0, load_err0}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // First two program words with idle gaps.
        push_word(32'hFD010113);
        send_stream(1'b0);
        check("w0_we", {31'b0, imem_we0}, 32'd1);
        check("w0_addr", {24'b0, imem_addr0}, 32'd0);
        check("w0_wdata", imem_wdata0, 32'hFD010113);
        @(negedge clk);
        check("w0_one_cycle", {31'b0, imem_we0}, 32'd0);
        push_word(32'h02812623);
        send_stream(1'b0);
        check("w1_addr", {24'b0, imem_addr0}, 32'd1);
        check("w1_wdata", imem_wdata0, 32'h02812623);

        // Partial word, then a break coincident with a byte; both discarded.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h6F;
        @(negedge clk); rx_data = 8'hF0;
        @(negedge clk); rx_data = 8'hAA; rx_break = 1'b1;
        @(negedge clk); rx_valid = 1'b0; rx_break = 1'b0;
        push_word(32'h00100793);
        send_stream(1'b0);
        check("brk_addr", {24'b0, imem_addr0}, 32'd2);
        check("brk_wdata", imem_wdata0, 32'h00100793);

        // Two words back-to-back: byte 0 of the second coincides with the strobe.
        push_word(32'h11223344);
        push_word(32'h55667788);
        send_stream(1'b1);
        check("b2b_addr", {24'b0, imem_addr0}, 32'd4);
        check("b2b_wdata", imem_wdata0, 32'h55667788);
        check("ovf_err1", {31'b0, load_err1}, 32'd1);
        check("ovf_core_rst1", {31'b0, core_rst1}, 32'd1);
        check("ovf_err0", {31'b0, load_err0}, 32'd0);

        // End marker, then a second marker that must be ignored.
        push_word(32'hFFFFFFFF);
        send_stream(1'b0);
        check("end_done", {31'b0, load_done0}, 32'd1);
        check("end_core_rst", {31'b0, core_rst0}, 32'd0);
        check("end_no_we", {31'b0, imem_we0}, 32'd0);
        push_word(32'hFFFFFFFF);
        push_word(32'h12345678);
        send_stream(1'b1);
        check("done_hold", {31'b0, load_done0}, 32'd1);
        check("done_no_we", {31'b0, imem_we0}, 32'd0);
        check("err_hold", {31'b0, load_err1}, 32'd1);

        // Reset in the cycle of a write strobe aborts it.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_word(32'hA5A5A5A5);
        send_stream(1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midwrite");
        rst = 1'b0;

        // Word 0 written, reset after two bytes of word 1, restart at 0.
        push_word(32'h0BADF00D);
        send_stream(1'b0);
        bq.push_back(8'h01);
        bq.push_back(8'h02);
        send_stream(1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midword");
        rst = 1'b0;
        push_word(32'hCAFEF00D);
        send_stream(1'b0);
        check("restart_we", {31'b0, imem_we0}, 32'd1);
        check("restart_addr", {24'b0, imem_addr0}, 32'd0);
        check("restart_wdata", imem_wdata0, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
